// File: rtl/alu_op_scheduler.sv
// Command FIFO and one-at-a-time issue sequencer for the shared multi-cycle ALU.
// A divide-by-zero command never reaches the ALU: it flushes the queue and halts until err_clr_i.
module alu_op_scheduler #(
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     req_valid_i,
    input  logic [3:0]               req_op_i,
    input  logic [3:0]               req_a_i,
    input  logic [3:0]               req_b_i,
    output logic                     req_ready_o,
    output logic [3:0]               alu_op_o,
    output logic [3:0]               alu_a_o,
    output logic [3:0]               alu_b_o,
    input  logic                     alu_busy_i,
    input  logic [7:0]               alu_result_i,
    output logic [7:0]               result_o,
    output logic [3:0]               result_op_o,
    output logic                     result_valid_o,
    output logic                     err_o,
    input  logic                     err_clr_i,
    output logic [$clog2(DEPTH):0]   level_o,
    output logic [7:0]               done_count_o
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = AW + 1;
    localparam logic [3:0]  OP_DIV = 4'b0001;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, HALT} state_t;
    typedef struct packed {
        logic [3:0] op;
        logic [3:0] a;
        logic [3:0] b;
    } cmd_t;

    state_t        state_q, state_d;
    cmd_t          mem_q [DEPTH];
    cmd_t          head;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [LW-1:0] level_q, level_d;
    logic [3:0]    op_q, op_d;
    logic [3:0]    alu_op_q, alu_op_d, alu_a_q, alu_a_d, alu_b_q, alu_b_d;
    logic [7:0]    result_q, result_d, done_q, done_d;
    logic [3:0]    result_op_q, result_op_d;
    logic          result_valid_q, result_valid_d, err_q, err_d;
    logic          push, pop, flush;

    assign head        = mem_q[rd_ptr_q];
    assign req_ready_o = (level_q != LW'(DEPTH)) && (state_q != HALT);
    assign push        = req_valid_i && req_ready_o && $onehot(req_op_i);

    always_comb begin
        state_d        = state_q;
        wr_ptr_d       = wr_ptr_q;
        rd_ptr_d       = rd_ptr_q;
        level_d        = level_q;
        op_d           = op_q;
        alu_op_d       = '0;
        alu_a_d        = alu_a_q;
        alu_b_d        = alu_b_q;
        result_d       = result_q;
        result_op_d    = result_op_q;
        result_valid_d = 1'b0;
        err_d          = err_q;
        done_d         = done_q;
        pop            = 1'b0;
        flush          = 1'b0;

        if (push) wr_ptr_d = wr_ptr_q + AW'(1);

        case (state_q)
            IDLE: begin
                if (level_q != '0) begin
                    pop      = 1'b1;
                    rd_ptr_d = rd_ptr_q + AW'(1);
                    if (head.op == OP_DIV && head.b == '0) begin
                        err_d   = 1'b1;
                        flush   = 1'b1;
                        state_d = HALT;
                    end else begin
                        op_d     = head.op;
                        alu_op_d = head.op;
                        alu_a_d  = head.a;
                        alu_b_d  = head.b;
                        state_d  = ISSUE;
                    end
                end
            end
            ISSUE: state_d = WAIT;
            WAIT: begin
                if (!alu_busy_i) begin
                    result_d       = alu_result_i;
                    result_op_d    = op_q;
                    result_valid_d = 1'b1;
                    done_d         = done_q + 8'd1;
                    state_d        = IDLE;
                end
            end
            HALT: begin
                if (err_clr_i) begin
                    err_d   = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // A flush discards everything, including a push landing in the same cycle.
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            level_d = level_q + LW'(push) - LW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= IDLE;
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            level_q        <= '0;
            op_q           <= '0;
            alu_op_q       <= '0;
            alu_a_q        <= '0;
            alu_b_q        <= '0;
            result_q       <= '0;
            result_op_q    <= '0;
            result_valid_q <= 1'b0;
            err_q          <= 1'b0;
            done_q         <= '0;
        end else begin
            state_q        <= state_d;
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            level_q        <= level_d;
            op_q           <= op_d;
            alu_op_q       <= alu_op_d;
            alu_a_q        <= alu_a_d;
            alu_b_q        <= alu_b_d;
            result_q       <= result_d;
            result_op_q    <= result_op_d;
            result_valid_q <= result_valid_d;
            err_q          <= err_d;
            done_q         <= done_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= {req_op_i, req_a_i, req_b_i};
    end

    assign alu_op_o       = alu_op_q;
    assign alu_a_o        = alu_a_q;
    assign alu_b_o        = alu_b_q;
    assign result_o       = result_q;
    assign result_op_o    = result_op_q;
    assign result_valid_o = result_valid_q;
    assign err_o          = err_q;
    assign level_o        = level_q;
    assign done_count_o   = done_q;
endmodule

// File: tb/tb_alu_op_scheduler.sv
// Bench for alu_op_scheduler: directed scenarios plus random traffic, with a behavioural ALU
// and an in-order expected-result queue as the reference.
module tb_alu_op_scheduler;
    localparam int DEPTH = 4;
    localparam int LW    = $clog2(DEPTH) + 1;

    typedef struct packed {
        logic [3:0] op;
        logic [3:0] a;
        logic [3:0] b;
    } cmd_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          req_valid_i = 1'b0;
    logic [3:0]    req_op_i = '0, req_a_i = '0, req_b_i = '0;
    logic          req_ready_o;
    logic [3:0]    alu_op_o, alu_a_o, alu_b_o;
    logic          alu_busy_i = 1'b0;
    logic [7:0]    alu_result_i = '0;
    logic [7:0]    result_o;
    logic [3:0]    result_op_o;
    logic          result_valid_o;
    logic          err_o;
    logic          err_clr_i = 1'b0;
    logic [LW-1:0] level_o;
    logic [7:0]    done_count_o;

    alu_op_scheduler #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .req_valid_i(req_valid_i), .req_op_i(req_op_i), .req_a_i(req_a_i), .req_b_i(req_b_i),
        .req_ready_o(req_ready_o),
        .alu_op_o(alu_op_o), .alu_a_o(alu_a_o), .alu_b_o(alu_b_o),
        .alu_busy_i(alu_busy_i), .alu_result_i(alu_result_i),
        .result_o(result_o), .result_op_o(result_op_o), .result_valid_o(result_valid_o),
        .err_o(err_o), .err_clr_i(err_clr_i), .level_o(level_o), .done_count_o(done_count_o)
    );

    always #5 clk = ~clk;

    int   errors = 0, checks = 0;
    cmd_t exp_q[$];
    cmd_t pend_cmd;
    logic acc_next = 1'b0, halt_m = 1'b0, lvl_chk = 1'b1;
    int   accepted = 0, issued = 0, done_m = 0, strobes = 0;
    logic alu_pend = 1'b0, prev_strobe = 1'b0, busy_rand = 1'b0;
    logic [3:0] alu_op_l = '0;
    int   alu_cnt = 0, busy_len = 0;

    function automatic logic [7:0] alu_fn(input logic [3:0] op, input logic [3:0] a, input logic [3:0] b);
        case (op)
            4'b1000: return 8'(a) + 8'(b);
            4'b0100: return 8'(a) - 8'(b);
            4'b0010: return 8'(a) * 8'(b);
            4'b0001: return (b == 4'd0) ? 8'hff : 8'(a / b);
            default: return 8'h00;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: account the push sampled at this edge, step the ALU model, check outputs.
    task automatic tick();
        cmd_t c;
        @(posedge clk);
        #1;
        if (acc_next) begin
            accepted++;
            if (!(pend_cmd.op == 4'b0001 && pend_cmd.b == 4'd0)) exp_q.push_back(pend_cmd);
            acc_next = 1'b0;
        end
        if (rst) begin
            alu_pend = 1'b0; alu_busy_i = 1'b0; prev_strobe = 1'b0;
        end else if (alu_op_o != 4'd0) begin
            chk("strobe_one_cycle", 32'(prev_strobe), 32'd0);
            chk("strobe_onehot", 32'($onehot(alu_op_o)), 32'd1);
            strobes++; issued++;
            alu_op_l = alu_op_o;
            alu_cnt = busy_rand ? int'($urandom_range(0, 3)) : busy_len;
            alu_pend = 1'b1; alu_busy_i = 1'b0; alu_result_i = 8'($urandom);
            prev_strobe = 1'b1;
        end else begin
            prev_strobe = 1'b0;
            if (alu_pend) begin
                if (alu_cnt > 0) begin
                    alu_busy_i = 1'b1; alu_cnt--; alu_result_i = 8'($urandom);
                end else begin
                    alu_busy_i = 1'b0; alu_pend = 1'b0;
                    alu_result_i = alu_fn(alu_op_l, alu_a_o, alu_b_o);
                end
            end
        end
        if (!rst && lvl_chk) chk("level", 32'(level_o), 32'(accepted - issued));
        if (result_valid_o) begin
            chk("valid_has_pending", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                c = exp_q.pop_front();
                done_m++;
                chk("result_op", 32'(result_op_o), 32'(c.op));
                chk("result_val", 32'(result_o), 32'(alu_fn(c.op, c.a, c.b)));
                chk("done_count", 32'(done_count_o), 32'(done_m % 256));
            end
        end
    endtask

    task automatic push(input logic [3:0] op, input logic [3:0] a, input logic [3:0] b);
        logic rdy_m;
        rdy_m = ((accepted - issued) != DEPTH) && !halt_m;
        chk("req_ready", 32'(req_ready_o), 32'(rdy_m));
        req_valid_i = 1'b1; req_op_i = op; req_a_i = a; req_b_i = b;
        acc_next = rdy_m && $onehot(op);
        pend_cmd = {op, a, b};
        tick();
        req_valid_i = 1'b0;
    endtask

    task automatic check_reset();
        chk("rst_alu_op", 32'(alu_op_o), 32'd0);
        chk("rst_alu_a", 32'(alu_a_o), 32'd0);
        chk("rst_alu_b", 32'(alu_b_o), 32'd0);
        chk("rst_result", 32'(result_o), 32'd0);
        chk("rst_result_op", 32'(result_op_o), 32'd0);
        chk("rst_valid", 32'(result_valid_o), 32'd0);
        chk("rst_err", 32'(err_o), 32'd0);
        chk("rst_level", 32'(level_o), 32'd0);
        chk("rst_done", 32'(done_count_o), 32'd0);
        chk("rst_ready", 32'(req_ready_o), 32'd1);
    endtask

    initial begin
        int n, s0, d0, v;
        tick(); tick();
        check_reset();
        rst = 1'b0;
        tick();

        // Single add, busy never raised
        busy_len = 0;
        push(4'b1000, 4'd3, 4'd5);
        tick();
        chk("add_strobe_op", 32'(alu_op_o), 32'b1000);
        chk("add_strobe_a", 32'(alu_a_o), 32'd3);
        chk("add_strobe_b", 32'(alu_b_o), 32'd5);
        tick();
        chk("add_strobe_off", 32'(alu_op_o), 32'd0);
        chk("add_a_held", 32'(alu_a_o), 32'd3);
        tick();
        chk("add_valid_at_3", 32'(result_valid_o), 32'd1);
        chk("add_result", 32'(result_o), 32'd8);
        chk("add_done", 32'(done_count_o), 32'd1);
        tick();
        chk("add_valid_pulse", 32'(result_valid_o), 32'd0);
        chk("add_result_held", 32'(result_o), 32'd8);

        // Multi-cycle mul: busy 4 cycles
        busy_len = 4; s0 = strobes;
        push(4'b0010, 4'd7, 4'd9);
        n = 0;
        while (!result_valid_o && n < 30) begin tick(); n++; end
        chk("mul_latency", 32'(n), 32'd7);
        chk("mul_result_op", 32'(result_op_o), 32'b0010);
        chk("mul_result", 32'(result_o), 32'd63);
        chk("mul_operands_held", 32'({alu_a_o, alu_b_o}), 32'h79);
        chk("mul_one_strobe", 32'(strobes - s0), 32'd1);
        tick();

        // Fill/full under a long busy
        busy_len = 30; s0 = strobes; d0 = done_m;
        push(4'b1000, 4'd1, 4'd2);
        push(4'b0100, 4'd9, 4'd3);
        push(4'b0010, 4'd3, 4'd4);
        push(4'b0001, 4'd8, 4'd2);
        push(4'b1000, 4'd15, 4'd15);
        chk("full_level", 32'(level_o), 32'd4);
        chk("full_not_ready", 32'(req_ready_o), 32'd0);
        push(4'b0100, 4'd5, 4'd5);
        chk("full_drop_level", 32'(level_o), 32'd4);
        busy_len = 0; alu_cnt = 0;
        n = 0;
        while (done_m != d0 + 5 && n < 100) begin tick(); n++; end
        chk("full_drained", 32'(done_m - d0), 32'd5);
        chk("full_strobes", 32'(strobes - s0), 32'd5);
        chk("full_queue_empty", 32'(exp_q.size()), 32'd0);

        // Divide-by-zero halts and flushes
        lvl_chk = 1'b0; s0 = strobes;
        push(4'b1000, 4'd2, 4'd2);
        push(4'b0001, 4'd6, 4'd0);
        push(4'b0100, 4'd9, 4'd4);
        n = 0;
        while (!err_o && n < 10) begin tick(); n++; end
        chk("div0_latency", 32'(n), 32'd2);
        chk("div0_err", 32'(err_o), 32'd1);
        chk("div0_level", 32'(level_o), 32'd0);
        chk("div0_not_ready", 32'(req_ready_o), 32'd0);
        repeat (4) tick();
        chk("div0_only_add_issued", 32'(strobes - s0), 32'd1);
        chk("div0_err_sticky", 32'(err_o), 32'd1);
        chk("div0_done_held", 32'(done_count_o), 32'(done_m % 256));
        exp_q.delete(); accepted = issued; halt_m = 1'b1;
        push(4'b1000, 4'd1, 4'd1);
        chk("halt_push_refused", 32'(level_o), 32'd0);
        err_clr_i = 1'b1;
        tick();
        err_clr_i = 1'b0;
        halt_m = 1'b0; lvl_chk = 1'b1;
        chk("clr_err", 32'(err_o), 32'd0);
        chk("clr_ready", 32'(req_ready_o), 32'd1);
        d0 = done_m;
        push(4'b0100, 4'd9, 4'd4);
        n = 0;
        while (done_m == d0 && n < 20) begin tick(); n++; end
        chk("post_clr_sub_done", 32'(done_m - d0), 32'd1);
        chk("post_clr_strobes", 32'(strobes - s0), 32'd2);

        // Invalid ops are dropped
        s0 = strobes;
        push(4'b0110, 4'd1, 4'd1);
        push(4'b0000, 4'd2, 4'd2);
        repeat (3) tick();
        chk("invalid_level", 32'(level_o), 32'd0);
        chk("invalid_no_strobe", 32'(strobes - s0), 32'd0);

        // Reset in the middle of WAIT
        busy_len = 10;
        push(4'b1000, 4'd1, 4'd2);
        repeat (4) tick();
        chk("midwait_busy", 32'(alu_busy_i), 32'd1);
        rst = 1'b1;
        tick();
        check_reset();
        rst = 1'b0;
        exp_q.delete(); accepted = 0; issued = 0; done_m = 0; acc_next = 1'b0;
        v = 0;
        repeat (15) begin tick(); if (result_valid_o) v++; end
        chk("no_valid_after_reset", 32'(v), 32'd0);
        chk("done_after_reset", 32'(done_count_o), 32'd0);

        // Random traffic
        busy_rand = 1'b1;
        for (int i = 0; i < 120; i++) begin
            logic [3:0] op, a, b;
            if ($urandom_range(0, 2) != 0) begin
                case ($urandom_range(0, 8))
                    0: op = 4'b1000; 1: op = 4'b0100; 2: op = 4'b0010; 3: op = 4'b0001;
                    4: op = 4'b1000; 5: op = 4'b0010; 6: op = 4'b0100;
                    default: op = 4'($urandom_range(0, 15)) & 4'b0101 | 4'b0101 & {4{i[0]}};
                endcase
                a = 4'($urandom);
                b = (op == 4'b0001) ? 4'($urandom_range(1, 15)) : 4'($urandom);
                push(op, a, b);
            end else begin
                tick();
            end
        end
        n = 0;
        while ((exp_q.size() != 0 || accepted != issued) && n < 500) begin tick(); n++; end
        repeat (8) tick();
        chk("rand_drained", 32'(exp_q.size()), 32'd0);
        chk("rand_level_zero", 32'(level_o), 32'd0);
        chk("rand_done_count", 32'(done_count_o), 32'(done_m % 256));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
